ripple_add_seq: RTL and testbench



---
 rtl/ripple_add_seq.sv | 140 ++++++++++++++
 tb/tb_ripple_add_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ripple_add_seq.sv
// Word-serial wide adder: one DATA_WIDTH-bit ripple-carry adder reused CHUNKS times, LSB chunk first.
// Optional macro RIPPLE_ADD_SEQ_SUB_EN adds in_sub for A-B (two's complement) operation.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_add_seq #(
   parameter  int DATA_WIDTH = 4,
   parameter  int CHUNKS     = 4,
   localparam int W          = DATA_WIDTH * CHUNKS,
   localparam int IDX_W      = $clog2(CHUNKS)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_ci,
`ifdef RIPPLE_ADD_SEQ_SUB_EN
   input  logic         in_sub,
`endif
   input  logic         in_vld,
   output logic         in_rd,
   output logic [W-1:0] out_s,
   output logic         out_co,
   output logic         out_vld,
   input  logic         out_rd,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [CHUNKS-1:0][DATA_WIDTH-1:0] a;
      logic [CHUNKS-1:0][DATA_WIDTH-1:0] b;
      logic                              sub;
   } req_t;

   state_t                            state, state_nxt;
   req_t                              req_q;
   logic [IDX_W-1:0]                  idx;
   logic                              carry;
   logic [CHUNKS-1:0][DATA_WIDTH-1:0] sum_q;
   logic                              co_q;
   logic                              last;
   logic                              sub_in;

`ifdef RIPPLE_ADD_SEQ_SUB_EN
   assign sub_in = in_sub;
`else
   assign sub_in = 1'b0;
`endif

   assign last = (idx == IDX_W'(CHUNKS - 1));

   // Shared adder: subtraction feeds the inverted B chunk, chunk-0 carry forced to 1 at accept
   logic [DATA_WIDTH-1:0] add_a, add_b, add_s;
   logic [DATA_WIDTH:0]   add_c;

   assign add_a    = req_q.a[idx];
   assign add_b    = req_q.b[idx] ^ {DATA_WIDTH{req_q.sub}};
   assign add_c[0] = carry;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a  (add_a[i]),
         .b  (add_b[i]),
         .ci (add_c[i]),
         .s  (add_s[i]),
         .co (add_c[i+1])
      );
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_vld)  state_nxt = RUN;
         RUN:     if (last)    state_nxt = DONE;
         DONE:    if (out_rd)  state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      in_rd   = (state == IDLE);
      out_vld = (state == DONE);
      busy    = (state != IDLE);
   end

   // Datapath: operand latch, per-chunk result write, inter-chunk carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
         idx   <= '0;
         carry <= 1'b0;
         sum_q <= '0;
         co_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_vld) begin
               req_q.a   <= in_a;
               req_q.b   <= in_b;
               req_q.sub <= sub_in;
               carry     <= sub_in ? 1'b1 : in_ci;
               idx       <= '0;
            end
            RUN: begin
               sum_q[idx] <= add_s;
               carry      <= add_c[DATA_WIDTH];
               if (last) begin
                  co_q <= add_c[DATA_WIDTH];
                  idx  <= '0;
               end else begin
                  idx  <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_s  = sum_q;
   assign out_co = co_q;

endmodule

// File: tb/tb_ripple_add_seq.sv
// Scoreboard bench for ripple_add_seq: expected sums queued at acceptance, checked on output handshake.
// Define RIPPLE_ADD_SEQ_SUB_EN to also exercise subtraction.

module tb_ripple_add_seq;
   localparam int DW = 4;
   localparam int CH = 4;
   localparam int W  = DW * CH;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         in_ci = 1'b0, in_sub = 1'b0, in_vld = 1'b0, out_rd = 1'b1;
   logic         in_rd, out_co, out_vld, busy;
   logic [W-1:0] out_s;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W:0] sb[$];
   logic [W:0] e_mon;

   always #5 clk = ~clk;

   ripple_add_seq #(.DATA_WIDTH(DW), .CHUNKS(CH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_a    (in_a),
      .in_b    (in_b),
      .in_ci   (in_ci),
`ifdef RIPPLE_ADD_SEQ_SUB_EN
      .in_sub  (in_sub),
`endif
      .in_vld  (in_vld),
      .in_rd   (in_rd),
      .out_s   (out_s),
      .out_co  (out_co),
      .out_vld (out_vld),
      .out_rd  (out_rd),
      .busy    (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci, input logic sub);
      if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
   endfunction

   // Output monitor: handshake completes on the next rising edge
   always @(negedge clk) begin
      if (rst_n && out_vld && out_rd) begin
         if (sb.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            e_mon = sb.pop_front();
            chk("sum", {out_co, out_s}, e_mon);
         end
      end
   end

   // Drive an operand pair until accepted; returns 1 time unit after the accepting edge
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
      logic ok;
      bit   done = 0;
      in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_vld = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk); ok = in_rd;
         @(posedge clk); #1;
         if (ok) done = 1;
      end
      if (!done) chk("send_timeout", 1, 0);
      else sb.push_back(model(a, b, ci, sub));
      in_vld = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_ci = 1'(~ci); in_sub = 1'(~sub);
   endtask

   task automatic wait_vld(output int n);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (out_vld) begin n = i; break; end
      end
      if (n == 0) chk("vld_timeout", 1, 0);
   endtask

   task automatic drain(input bit rand_bp);
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         out_rd = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         if (!busy) done = 1;
      end
      if (!done) chk("drain_timeout", 1, 0);
      out_rd = 1'b1;
   endtask

   initial begin
      int n;
      logic [W-1:0] s0;
      logic         c0;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_vld", out_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_s", out_s, 0);
      chk("rst_out_co", out_co, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_rd", in_rd, 1);

      // Basic add with latency check
      send(16'h1234, 16'h0101, 1'b0, 1'b0);
      chk("busy_run", busy, 1);
      wait_vld(n);
      chk("latency", n, CH);
      chk("basic_s", out_s, 16'h1335);
      drain(0);

      // Full carry ripple through every chunk
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      wait_vld(n);
      chk("ripple_latency", n, CH);
      chk("ripple_s", out_s, 16'h0000);
      chk("ripple_co", out_co, 1);
      drain(0);

      // Backpressure in DONE, ignored input pulse, same-cycle out_rd+in_vld
      out_rd = 1'b0;
      send(16'hABCD, 16'h1111, 1'b0, 1'b0);
      wait_vld(n);
      s0 = out_s; c0 = out_co;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin in_a = 16'h5555; in_b = 16'h5555; in_vld = 1'b1; end
         if (i == 5) in_vld = 1'b0;
         @(negedge clk);
         chk("bp_s_stable", out_s, s0);
         chk("bp_co_stable", out_co, c0);
         chk("bp_in_rd", in_rd, 0);
         chk("bp_out_vld", out_vld, 1);
         @(posedge clk); #1;
      end
      out_rd = 1'b1; in_vld = 1'b1;
      @(posedge clk); #1;
      in_vld = 1'b0;
      chk("done_no_accept_busy", busy, 0);
      chk("done_to_idle_in_rd", in_rd, 1);
      send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
      drain(0);

      // Random operands under random backpressure
      for (int k = 0; k < 8; k++) begin
         send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         drain(1);
      end

      // Asynchronous reset mid-operation
      send(16'h7777, 16'h8888, 1'b1, 1'b0);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_vld", out_vld, 0);
      chk("midrst_out_s", out_s, 0);
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_vld(n);
      chk("post_rst_s", out_s, 16'h0002);
      drain(0);

`ifdef RIPPLE_ADD_SEQ_SUB_EN
      send(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_vld(n);
      chk("sub_neg_s", out_s, 16'hFFFE);
      chk("sub_neg_co", out_co, 0);
      drain(0);
      send(16'h0007, 16'h0005, 1'b0, 1'b1);
      wait_vld(n);
      chk("sub_pos_s", out_s, 16'h0002);
      chk("sub_pos_co", out_co, 1);
      drain(0);
      for (int k = 0; k < 4; k++) begin
         send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         drain(1);
      end
`endif

      repeat (2) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
